// File: rtl/gfx256_pkg.sv
// Shared types for the 256-bit orgfx fragment stage: FSM state encoding,
// texture colour-depth codes, and the colour/alpha helper functions.
package gfx256_pkg;

   typedef enum logic [2:0] {
      S_WAIT,
      S_DELAY1,
      S_DELAY2,
      S_TEX_READ,
      S_WRITE_PIXEL
   } frag_state_t;

   localparam logic [1:0] CD_8  = 2'b00;
   localparam logic [1:0] CD_16 = 2'b01;
   localparam logic [1:0] CD_32 = 2'b11;

   // Bits of a 32-bit colour word that are meaningful at a given depth.
   function automatic logic [31:0] depth_mask(input logic [1:0] cd);
      logic [31:0] m;
      case (cd)
         CD_8:    m = 32'h0000_00FF;
         CD_16:   m = 32'h0000_FFFF;
         default: m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

   // a*t/255 approximation, exact at both ends (0 and 255).
   function automatic logic [7:0] modulate_alpha(input logic [7:0] a, input logic [7:0] t);
      logic [15:0] p;
      p = 16'(a) * 16'(t) + 16'(a) + 16'(t);
      return 8'(p >> 8);
   endfunction

endpackage

// File: rtl/gfx_calc_address.sv
// Maps a pixel coordinate to a memory line address plus the byte offset
// of that pixel inside the SW-bit line.
module gfx_calc_address
   import gfx256_pkg::*;
#(
   parameter int unsigned SW          = 256,
   parameter int unsigned point_width = 16,
   parameter int unsigned LW          = $clog2(SW/8)
) (
   input  logic [31:0]            i_base_address,
   input  logic [1:0]             i_color_depth,
   input  logic [point_width-1:0] i_x,
   input  logic [point_width-1:0] i_y,
   input  logic [point_width-1:0] i_width,
   output logic [31:0]            o_address,
   output logic [LW-1:0]          o_mb
);

   logic [31:0] w_pix;
   logic [31:0] w_off;
   logic [31:0] w_byte;

   always_comb begin
      w_pix = 32'(i_y) * 32'(i_width) + 32'(i_x);
      case (i_color_depth)
         CD_8:    w_off = w_pix;
         CD_16:   w_off = w_pix << 1;
         default: w_off = w_pix << 2;
      endcase
      w_byte    = i_base_address + w_off;
      o_address = {w_byte[31:LW], {LW{1'b0}}};
      o_mb      = w_byte[LW-1:0];
   end

endmodule

// File: rtl/memory_to_color256.sv
// Extracts one little-endian texel from a memory line, starting at byte
// offset i_mb, masked down to the active colour depth.
module memory_to_color256
   import gfx256_pkg::*;
#(
   parameter int unsigned SW = 256,
   parameter int unsigned LW = $clog2(SW/8)
) (
   input  logic [1:0]    i_color_depth,
   input  logic [SW-1:0] i_mem,
   input  logic [LW-1:0] i_mb,
   output logic [31:0]   o_color
);

   logic [31:0] w_raw;

   always_comb begin
      w_raw = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         w_raw[k*8 +: 8] = i_mem[{LW'(i_mb + LW'(k)), 3'b000} +: 8];
      end
      o_color = w_raw & depth_mask(i_color_depth);
   end

endmodule

// File: rtl/gfx256_fragment.sv
// Fragment stage: optional texel fetch, colour-key rejection and texel-alpha
// modulation between the clip/z-check stage and the blender.
module gfx256_fragment
   import gfx256_pkg::*;
#(
   parameter int unsigned point_width = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   texture_enable_i,
   input  logic                   colorkey_enable_i,
   input  logic [31:0]            colorkey_i,
   input  logic [1:0]             color_depth_i,
   input  logic [31:0]            tex0_base_i,
   input  logic [point_width-1:0] tex0_size_x_i,
   input  logic [point_width-1:0] tex0_size_y_i,
   input  logic [point_width-1:0] pixel_x_i,
   input  logic [point_width-1:0] pixel_y_i,
   input  logic [point_width-1:0] pixel_z_i,
   input  logic [point_width-1:0] u_i,
   input  logic [point_width-1:0] v_i,
   input  logic [7:0]             a_i,
   input  logic [31:0]            color_i,
   input  logic                   write_i,
   output logic                   ack_o,
   output logic                   tex_request_o,
   output logic [31:0]            tex_addr_o,
   output logic [31:0]            tex_sel_o,
   input  logic [255:0]           tex_data_i,
   input  logic                   tex_ack_i,
   output logic [point_width-1:0] pixel_x_o,
   output logic [point_width-1:0] pixel_y_o,
   output logic [point_width-1:0] pixel_z_o,
   output logic [31:0]            color_o,
   output logic [7:0]             a_o,
   output logic                   write_o,
   input  logic                   ack_i
);

   localparam int unsigned LW = 5;

   frag_state_t            r_state;
   logic [point_width-1:0] r_u, r_v;
   logic [point_width-1:0] r_tu, r_tv;
   logic [7:0]             r_a;
   logic [LW-1:0]          r_mb;

   logic [31:0]            w_addr;
   logic [LW-1:0]          w_mb;
   logic [31:0]            w_texel;
   logic [7:0]             w_talpha;
   logic                   w_key_hit;

   assign tex_sel_o = '1;

   gfx_calc_address #(
      .SW          (256),
      .point_width (point_width),
      .LW          (LW)
   ) u_calc (
      .i_base_address (tex0_base_i),
      .i_color_depth  (color_depth_i),
      .i_x            (r_tu),
      .i_y            (r_tv),
      .i_width        (tex0_size_x_i),
      .o_address      (w_addr),
      .o_mb           (w_mb)
   );

   memory_to_color256 #(
      .SW (256),
      .LW (LW)
   ) u_m2c (
      .i_color_depth (color_depth_i),
      .i_mem         (tex_data_i),
      .i_mb          (r_mb),
      .o_color       (w_texel)
   );

   always_comb begin
      w_talpha  = (color_depth_i == CD_32) ? w_texel[31:24] : 8'hFF;
      w_key_hit = colorkey_enable_i && (w_texel == (colorkey_i & depth_mask(color_depth_i)));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= S_WAIT;
         r_u           <= '0;
         r_v           <= '0;
         r_tu          <= '0;
         r_tv          <= '0;
         r_a           <= '0;
         r_mb          <= '0;
         ack_o         <= 1'b0;
         tex_request_o <= 1'b0;
         tex_addr_o    <= '0;
         pixel_x_o     <= '0;
         pixel_y_o     <= '0;
         pixel_z_o     <= '0;
         color_o       <= '0;
         a_o           <= '0;
         write_o       <= 1'b0;
      end else begin
         // ack_o is a single-cycle pulse; only the completing branches raise it.
         ack_o <= 1'b0;
         case (r_state)
            S_WAIT: begin
               if (write_i && !ack_o) begin
                  pixel_x_o <= pixel_x_i;
                  pixel_y_o <= pixel_y_i;
                  pixel_z_o <= pixel_z_i;
                  r_u       <= u_i;
                  r_v       <= v_i;
                  r_a       <= a_i;
                  if (texture_enable_i) begin
                     r_state <= S_DELAY1;
                  end else begin
                     color_o <= color_i;
                     a_o     <= a_i;
                     write_o <= 1'b1;
                     r_state <= S_WRITE_PIXEL;
                  end
               end
            end
            S_DELAY1: begin
               r_tu    <= (r_u >= tex0_size_x_i) ? tex0_size_x_i - point_width'(1) : r_u;
               r_tv    <= (r_v >= tex0_size_y_i) ? tex0_size_y_i - point_width'(1) : r_v;
               r_state <= S_DELAY2;
            end
            S_DELAY2: begin
               tex_addr_o    <= w_addr;
               r_mb          <= w_mb;
               tex_request_o <= 1'b1;
               r_state       <= S_TEX_READ;
            end
            S_TEX_READ: begin
               if (tex_ack_i) begin
                  tex_request_o <= 1'b0;
                  if (w_key_hit) begin
                     ack_o   <= 1'b1;
                     r_state <= S_WAIT;
                  end else begin
                     color_o <= w_texel;
                     a_o     <= modulate_alpha(r_a, w_talpha);
                     write_o <= 1'b1;
                     r_state <= S_WRITE_PIXEL;
                  end
               end
            end
            S_WRITE_PIXEL: begin
               if (ack_i) begin
                  write_o <= 1'b0;
                  ack_o   <= 1'b1;
                  r_state <= S_WAIT;
               end
            end
            default: r_state <= S_WAIT;
         endcase
      end
   end

endmodule

// File: tb/tb_gfx256_fragment.sv
// Directed bench for gfx256_fragment: table of pixel vectors plus
// hand-written hold and reset sequences.
module tb_gfx256_fragment;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         texture_enable_i, colorkey_enable_i;
   logic [31:0]  colorkey_i;
   logic [1:0]   color_depth_i;
   logic [31:0]  tex0_base_i;
   logic [15:0]  tex0_size_x_i, tex0_size_y_i;
   logic [15:0]  pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i;
   logic [7:0]   a_i;
   logic [31:0]  color_i;
   logic         write_i;
   logic         ack_o, tex_request_o;
   logic [31:0]  tex_addr_o, tex_sel_o;
   logic [255:0] tex_data_i;
   logic         tex_ack_i;
   logic [15:0]  pixel_x_o, pixel_y_o, pixel_z_o;
   logic [31:0]  color_o;
   logic [7:0]   a_o;
   logic         write_o, ack_i;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk_i = ~clk_i;

   gfx256_fragment #(.point_width(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .texture_enable_i(texture_enable_i), .colorkey_enable_i(colorkey_enable_i),
      .colorkey_i(colorkey_i), .color_depth_i(color_depth_i),
      .tex0_base_i(tex0_base_i), .tex0_size_x_i(tex0_size_x_i), .tex0_size_y_i(tex0_size_y_i),
      .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
      .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i), .write_i(write_i),
      .ack_o(ack_o), .tex_request_o(tex_request_o), .tex_addr_o(tex_addr_o),
      .tex_sel_o(tex_sel_o), .tex_data_i(tex_data_i), .tex_ack_i(tex_ack_i),
      .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
      .color_o(color_o), .a_o(a_o), .write_o(write_o), .ack_i(ack_i)
   );

   typedef struct {
      logic        tex_en;
      logic        ck_en;
      logic [31:0] ck;
      logic [1:0]  cd;
      logic [15:0] u, v;
      logic [31:0] color;
      logic [7:0]  a;
      logic [31:0] texel;
      logic        reject;
      logic [31:0] exp_addr;
      int unsigned exp_mb;
      logic [31:0] exp_color;
      logic [7:0]  exp_a;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [255:0] build_line(input logic [31:0] texel, input int unsigned mb,
                                               input logic [1:0] cd);
      logic [255:0] line;
      int unsigned nbytes;
      line   = {8{32'hDEADBEEF}};
      nbytes = (cd == 2'b00) ? 1 : (cd == 2'b01) ? 2 : 4;
      for (int unsigned b = 0; b < nbytes; b++)
         line[((mb + b) % 32) * 8 +: 8] = texel[b*8 +: 8];
      return line;
   endfunction

   task automatic apply(input vec_t t, input int idx);
      int n;
      texture_enable_i  = t.tex_en;
      colorkey_enable_i = t.ck_en;
      colorkey_i        = t.ck;
      color_depth_i     = t.cd;
      u_i = t.u; v_i = t.v;
      color_i = t.color; a_i = t.a;
      pixel_x_i = 16'(idx + 10); pixel_y_i = 16'(idx + 20); pixel_z_i = 16'(idx + 30);
      write_i = 1'b1;
      if (t.tex_en) begin
         n = 0;
         do begin tick(); n++; end while (!tex_request_o && n < 10);
         check($sformatf("v%0d req_latency", idx), 32'(n), 32'd3);
         check($sformatf("v%0d tex_addr", idx), tex_addr_o, t.exp_addr);
         check($sformatf("v%0d tex_sel", idx), tex_sel_o, 32'hFFFFFFFF);
         tick(); tick();
         check($sformatf("v%0d req_hold", idx), {31'd0, tex_request_o}, 32'd1);
         check($sformatf("v%0d addr_stable", idx), tex_addr_o, t.exp_addr);
         tex_data_i = build_line(t.texel, t.exp_mb, t.cd);
         tex_ack_i  = 1'b1;
         tick();
         tex_ack_i  = 1'b0;
         tex_data_i = '0;
         check($sformatf("v%0d req_drop", idx), {31'd0, tex_request_o}, 32'd0);
      end else begin
         tick();
      end
      if (t.reject) begin
         check($sformatf("v%0d rej_ack", idx), {31'd0, ack_o}, 32'd1);
         check($sformatf("v%0d rej_nowrite", idx), {31'd0, write_o}, 32'd0);
         write_i = 1'b0;
         tick();
         check($sformatf("v%0d rej_ack_pulse", idx), {30'd0, ack_o, write_o}, 32'd0);
      end else begin
         check($sformatf("v%0d write_o", idx), {31'd0, write_o}, 32'd1);
         check($sformatf("v%0d ack_early", idx), {31'd0, ack_o}, 32'd0);
         check($sformatf("v%0d color_o", idx), color_o, t.exp_color);
         check($sformatf("v%0d a_o", idx), {24'd0, a_o}, {24'd0, t.exp_a});
         check($sformatf("v%0d xyz", idx), {pixel_x_o[7:0], pixel_y_o[7:0], pixel_z_o[7:0], 8'd0},
               {8'(idx + 10), 8'(idx + 20), 8'(idx + 30), 8'd0});
         tick();
         check($sformatf("v%0d write_hold", idx), {31'd0, write_o}, 32'd1);
         ack_i = 1'b1;
         tick();
         ack_i = 1'b0;
         check($sformatf("v%0d ack_o", idx), {30'd0, ack_o, write_o}, 32'd2);
         write_i = 1'b0;
         tick();
         check($sformatf("v%0d ack_pulse", idx), {31'd0, ack_o}, 32'd0);
      end
   endtask

   initial begin
      // tex_en ck_en ck cd u v color a texel reject exp_addr exp_mb exp_color exp_a
      vecs.push_back('{1'b0, 1'b0, 32'h0, 2'b11, 16'd0, 16'd0, 32'h11223344, 8'h80, 32'h0, 1'b0, 32'h0, 0, 32'h11223344, 8'h80});
      vecs.push_back('{1'b0, 1'b0, 32'h0, 2'b11, 16'd0, 16'd0, 32'hFFFFFFFF, 8'h00, 32'h0, 1'b0, 32'h0, 0, 32'hFFFFFFFF, 8'h00});
      vecs.push_back('{1'b1, 1'b0, 32'h0, 2'b11, 16'd3, 16'd2, 32'h0, 8'hFF, 32'h80AABBCC, 1'b0, 32'h1200, 12, 32'h80AABBCC, 8'h80});
      vecs.push_back('{1'b1, 1'b1, 32'h00FF00FF, 2'b11, 16'd5, 16'd1, 32'h0, 8'hFF, 32'h00FF00FF, 1'b1, 32'h1100, 20, 32'h0, 8'h0});
      vecs.push_back('{1'b1, 1'b0, 32'h0, 2'b11, 16'd100, 16'd2, 32'h0, 8'h40, 32'h12345678, 1'b0, 32'h12E0, 28, 32'h12345678, 8'h04});
      vecs.push_back('{1'b1, 1'b0, 32'h0, 2'b11, 16'd0, 16'd70, 32'h0, 8'h00, 32'hFFFFFFFF, 1'b0, 32'h4F00, 0, 32'hFFFFFFFF, 8'h00});
      vecs.push_back('{1'b1, 1'b1, 32'h00FF00FF, 2'b11, 16'd1, 16'd0, 32'h0, 8'hFF, 32'h00FF00FE, 1'b0, 32'h1000, 4, 32'h00FF00FE, 8'h00});
      vecs.push_back('{1'b1, 1'b0, 32'h0, 2'b01, 16'd3, 16'd2, 32'h0, 8'h80, 32'h0000ABCD, 1'b0, 32'h1100, 6, 32'h0000ABCD, 8'h80});
      vecs.push_back('{1'b1, 1'b1, 32'h00000042, 2'b00, 16'd7, 16'd1, 32'h0, 8'hFF, 32'h00000042, 1'b1, 32'h1040, 7, 32'h0, 8'h0});

      rst_i = 1'b1;
      texture_enable_i = 0; colorkey_enable_i = 0; colorkey_i = '0; color_depth_i = 2'b11;
      tex0_base_i = 32'h1000; tex0_size_x_i = 16'd64; tex0_size_y_i = 16'd64;
      pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0; u_i = '0; v_i = '0;
      a_i = '0; color_i = '0; write_i = 0; tex_data_i = '0; tex_ack_i = 0; ack_i = 0;
      tick(); tick();
      check("rst_ctrl", {29'd0, write_o, ack_o, tex_request_o}, 32'd0);
      check("rst_color", color_o, 32'd0);
      check("rst_addr", tex_addr_o, 32'd0);
      check("rst_sel", tex_sel_o, 32'hFFFFFFFF);
      rst_i = 1'b0;
      tick();

      foreach (vecs[i]) apply(vecs[i], i);

      // write_i held one cycle past ack_o must not produce a second pixel
      texture_enable_i = 1'b0; color_i = 32'hCAFEF00D; a_i = 8'h11; write_i = 1'b1;
      tick();
      check("hold_write", {31'd0, write_o}, 32'd1);
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check("hold_ack", {31'd0, ack_o}, 32'd1);
      tick();
      write_i = 1'b0;
      begin
         int unsigned extra = 0;
         for (int k = 0; k < 5; k++) begin
            if (write_o || ack_o) extra++;
            tick();
         end
         check("hold_single_pixel", 32'(extra), 32'd0);
      end

      // reset while a fetch is outstanding; the late tex_ack_i must be ignored
      texture_enable_i = 1'b1; color_depth_i = 2'b11; u_i = 16'd3; v_i = 16'd2; a_i = 8'hFF;
      write_i = 1'b1;
      begin
         int n = 0;
         do begin tick(); n++; end while (!tex_request_o && n < 10);
         check("rst_fetch_req", {31'd0, tex_request_o}, 32'd1);
      end
      #3 rst_i = 1'b1;
      #1;
      check("rst_async", {30'd0, tex_request_o, write_o}, 32'd0);
      write_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tex_data_i = build_line(32'h80AABBCC, 12, 2'b11);
      tex_ack_i  = 1'b1;
      tick();
      tex_ack_i  = 1'b0;
      begin
         int unsigned stray = 0;
         for (int k = 0; k < 4; k++) begin
            if (write_o || ack_o || tex_request_o) stray++;
            tick();
         end
         check("rst_ack_ignored", 32'(stray), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gfx256_fragment.md
# gfx256_fragment

Fragment stage of the 256-bit orgfx pipeline, directly downstream of the clip/z-check stage and upstream of the blender. Accepts one clipped pixel at a time, optionally replaces its flat colour with a texel fetched from texture memory through the wishbone reader, applies colour-key rejection and texel-alpha modulation, and forwards the pixel to the blender. Uses a level-write / pulse-ack handshake on both sides.

## Interface
- point_width, 16, coordinate / u / v / z width
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- texture_enable_i  in  1  fetch texel at (u,v) instead of using color_i
- colorkey_enable_i  in  1  discard pixel when texel equals colorkey_i
- colorkey_i  in  32  key value, compared in color_depth_i format
- color_depth_i  in  2  texture colour depth code (pkg encoding)
- tex0_base_i  in  32  texture base byte address
- tex0_size_x_i, tex0_size_y_i  in  point_width  texture dimensions
- pixel_x_i, pixel_y_i, pixel_z_i, u_i, v_i  in  point_width  from clip
- a_i  in  8  alpha from clip
- color_i  in  32  flat colour from clip
- write_i  in  1  pixel valid, held until ack_o
- ack_o  out  1  one-cycle completion pulse to clip
- tex_request_o  out  1  read request to wishbone reader
- tex_addr_o  out  32  texel line address
- tex_sel_o  out  32  byte select, constant 32'hFFFFFFFF
- tex_data_i  in  256  returned memory line
- tex_ack_i  in  1  read done, tex_data_i valid this cycle
- pixel_x_o, pixel_y_o, pixel_z_o  out  point_width  to blender
- color_o  out  32;  a_o  out  8
- write_o  out  1  pixel valid to blender, held until ack_i
- ack_i  in  1  blender accepted pixel

## Operation
- States: WAIT, DELAY1, DELAY2, TEX_READ, WRITE_PIXEL.
- WAIT: on write_i & ~ack_o, register x/y/z/u/v/a/color. If texture_enable_i -> DELAY1; else write_o<=1, color_o<=color_i, a_o<=a_i -> WRITE_PIXEL. write_i while ack_o=1 is ignored (clip still holding the previous pixel).
- u/v clamped to size-1 when u>=tex0_size_x_i / v>=tex0_size_y_i (unsigned compare) before address calc.
- DELAY1 -> DELAY2 (address pipeline). DELAY2: tex_request_o<=1 -> TEX_READ.
- TEX_READ: hold tex_request_o until tex_ack_i; on ack drop request, extract texel. If colorkey_enable_i & texel==colorkey_i: ack_o<=1 -> WAIT, no write. Else color_o<=texel, a_o<=modulated alpha, write_o<=1 -> WRITE_PIXEL.
- Alpha: texel alpha t = texel[31:24] for 32 bpp, else 8'hFF; a_o = (a*t + a + t) >> 8 (16-bit intermediate; 255,255->255; 0,x->0).
- WRITE_PIXEL: on ack_i, write_o<=0, ack_o<=1 -> WAIT.
- Reset (any state): state WAIT; write_o, ack_o, tex_request_o, all data outputs 0; tex_sel_o all ones. In-flight fetch abandoned; tex_ack_i ignored outside TEX_READ.

## Timing
- Untextured: write_i sampled edge 0 -> write_o high after edge 0; ack_i at edge n -> ack_o high for cycle after edge n.
- Textured: write_i edge 0, tex_request_o high after edge 2, tex_ack_i edge k -> write_o (or ack_o on key reject) after edge k.
- ack_o always exactly one cycle; never coincident with write_o rising.
- tex_addr_o valid from DELAY2 until tex_ack_i; stable while request high.

## Structure
- State enum and colour-depth codes go in gfx256_pkg.
- Instantiate existing gfx_calc_address (SW=256) for tex_addr_o/mb and memory_to_color256 for texel extraction; no new sub-module.

## Test plan
- Untextured: write_i, color_i=32'h11223344, a_i=8'h80 -> write_o next cycle, color_o=32'h11223344, a_o=8'h80; ack_i -> one ack_o pulse.
- Textured 32 bpp: u=3,v=2, size 64x64, base 32'h1000 -> tex_addr_o matches gfx_calc_address; texel 32'h80AABBCC, a_i=FF -> color_o=32'h80AABBCC, a_o=8'h80.
- Colour key: texel==colorkey_i=32'h00FF00FF, enabled -> ack_o pulse, write_o never rises.
- Clamp: u=100 on size_x 64 -> address computed with u=63.
- Hold: write_i held one cycle past ack_o -> exactly one pixel emitted.
- Reset asserted in TEX_READ -> tex_request_o, write_o low immediately; later tex_ack_i ignored.
